rv32i_rob_mw: RTL and testbench
===============================

Name: rv32i_rob_mw

Overview:
Multi-writeback, multi-retire reorder buffer for the out-of-order RV32I core.
- Circular FIFO of in-flight instructions; one dispatch per cycle.
- Completion is marked through NUM_WB independent write-back ports.
- Up to RETIRE_W contiguous completed head entries retire per cycle to the register file / free list.
- Adds a pipeline flush, occupancy count and bypassed same-cycle completion.
- Sits between dispatcher, PU write-back buses and architectural register file commit.

Parameters:
- ROB_DEPTH, 16, number of entries. Power of 2, at least 2.
- NUM_WB, 2, number of write-back ports.
- RETIRE_W, 2, maximum retires per cycle. Range 1..ROB_DEPTH.
- IDX_BW, $clog2(ROB_DEPTH), derived entry-index width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset. Synchronous, active-high.
- i_dispatch  in  1  allocate request.
- i_dst_vld  in  1  instruction writes rd.
- i_dst_phys_rf_tag  in  PHYS_REG_FILE_IDX_BW  destination physical tag.
- i_dst_arch_rf_idx  in  ARCH_REG_FILE_IDX_BW  destination architectural index.
- o_rob_entry_idx  out  IDX_BW  entry allocated this cycle. Combinational, valid with i_dispatch & !o_full.
- o_full  out  1  count == ROB_DEPTH.
- o_empty  out  1  count == 0.
- o_count  out  IDX_BW+1  occupancy.
- i_wb_vld  in  NUM_WB  per-port write-back strobe.
- i_wb_rob_entry_idx  in  NUM_WB x IDX_BW  per-port entry index.
- i_flush  in  1  discard all entries.
- o_retire_vld  out  RETIRE_W  per-lane retire, lane 0 = oldest.
- o_retire_dst_vld  out  RETIRE_W  per-lane rd valid.
- o_retire_dst_phys_rf_tag  out  RETIRE_W x PHYS_REG_FILE_IDX_BW  per-lane tag.
- o_retire_dst_arch_rf_idx  out  RETIRE_W x ARCH_REG_FILE_IDX_BW  per-lane arch index.

Behaviour:
- Reset (rst=1 at posedge):
  - pointers, all entry vld/done and o_count cleared;
  - all retire outputs 0; o_empty=1, o_full=0.
  - Reset mid-operation drops everything; no retire on the following cycle.
- Pointers: wr_ptr and rd_ptr are IDX_BW+1 bits; MSB is the wrap parity.
  - o_full = equal indices with differing MSB; o_empty = pointers equal.
- Dispatch:
  - accepted iff i_dispatch & !o_full & !i_flush;
  - writes vld=1, done=0 and the payload at wr_idx; wr_ptr += 1.
  - A dispatch while full is dropped and all state is unchanged.
- Write-back:
  - each port with i_wb_vld sets done of the indexed entry only if that entry is vld.
  - Write-back to an invalid entry is ignored.
  - Duplicate indices across ports are idempotent.
- Effective done: done_eff[i] = done[i] | any-port hit on i (same-cycle bypass).
- Retire select, combinational:
  - n = number of contiguous done_eff & vld entries starting at rd_idx, capped at RETIRE_W and o_count.
  - Lanes 0..n-1 map to rd_idx+k modulo ROB_DEPTH, so wrap-around is allowed.
  - rd_ptr += n; retired entries clear vld/done.
- Retire outputs:
  - registered, appearing 1 cycle after the selecting edge;
  - o_retire_vld is thermometer (lane k set implies lane k-1 set);
  - payload is zero on non-retiring lanes.
- Simultaneous dispatch and retire in one cycle: o_count += accept − n.
  - A full ROB still rejects dispatch in a cycle where it retires; o_full reflects registered state only.
- Flush (i_flush=1):
  - next cycle pointers = 0, all vld/done = 0, o_count = 0;
  - dispatch, write-back and retire selection in the flush cycle are suppressed;
  - retire outputs are 0 on the next cycle.

Optional Feature:
Macro RV32I_ROB_EXC_EN.
- Defined:
  - adds i_wb_exc (NUM_WB) and a per-entry exc bit, set together with done;
  - retire selection stops after the first excepting entry, which retires as the last valid lane;
  - registered o_retire_exc (1) and o_retire_exc_rob_idx (IDX_BW) pulse with it;
  - further retire is blocked until i_flush;
  - dispatch still accepted until full.
- Undefined: these ports and the exc storage are absent; behaviour is exactly as above.

Decomposition:
- Package rv32i_pkg: ROB_DEPTH default, ROB_IDX_BW, PHYS_REG_FILE_IDX_BW, ARCH_REG_FILE_IDX_BW, and typedef rob_entry_t {vld, done, dst_vld, phys tag, arch idx, exc (under macro)}.
- Sub-module rv32i_rob_retire_sel: combinational contiguous-done scan from rd_idx producing n and the lane entry indices. It is parametrised by ROB_DEPTH and RETIRE_W.

Test Plan (defaults):
1. Reset: hold rst 2 cycles after random traffic -> o_empty=1, o_full=0, o_count=0, o_retire_vld=0, o_rob_entry_idx=0.
2. Ordering and bypass:
   - Dispatch tags 33/34/35 (arch 1/2/3) -> idx 0/1/2.
   - WB idx2, then idx0 on port1 -> next cycle lane0 only: tag 33, arch 1.
   - WB idx1 -> next cycle lanes 0,1 = tags 34, 35.
3. Full:
   - 16 dispatches -> o_full=1, o_count=16; a 17th dispatch is dropped and o_rob_entry_idx stays 0.
   - WB all 16 -> 2 retires/cycle for 8 cycles, then o_empty=1.
4. Wrap:
   - Stream 40 dispatches with 2-port WB and steady retire -> idx sequence wraps 15->0.
   - Retire lanes spanning entries 15,0 are correct; no spurious full/empty.
5. Flush: with 10 entries, WB pending and dispatch in the same cycle as i_flush -> next cycle o_count=0, o_retire_vld=0, next dispatch gets idx 0.
6. (RV32I_ROB_EXC_EN) Exception blocking:
   - Dispatch 4; WB idx0 plain, idx1 with exc, idx2 plain.
   - Response: lanes 0,1 retire; o_retire_exc=1 with idx 1; idx2 never retires; i_flush clears it.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared ROB sizing and entry layout; the exc field exists only with RV32I_ROB_EXC_EN.
// Pure declarations: no latency and no flow control.
package rv32i_pkg;

    localparam int ROB_DEPTH            = 16;
    localparam int ROB_IDX_BW           = $clog2(ROB_DEPTH);
    localparam int PHYS_REG_FILE_IDX_BW = 6;
    localparam int ARCH_REG_FILE_IDX_BW = 5;

    typedef struct packed {
        logic                            vld;
        logic                            done;
        logic                            dst_vld;
        logic [PHYS_REG_FILE_IDX_BW-1:0] phys_tag;
        logic [ARCH_REG_FILE_IDX_BW-1:0] arch_idx;
`ifdef RV32I_ROB_EXC_EN
        logic                            exc;
`endif
    } rob_entry_t;

endpackage

// File: rtl/rv32i_rob_retire_sel.sv
// Counts the contiguous completed entries from the head, capped at RETIRE_W and the occupancy.
// Combinational, zero latency; hold forces n=0 and a term entry ends the run after retiring itself.
module rv32i_rob_retire_sel #(
    parameter int ROB_DEPTH = 16,
    parameter int RETIRE_W  = 2,
    localparam int IDX_BW   = $clog2(ROB_DEPTH),
    localparam int NW       = $clog2(RETIRE_W + 1)
) (
    input  logic [IDX_BW-1:0]          rd_idx,
    input  logic [IDX_BW:0]            count,
    input  logic [ROB_DEPTH-1:0]       done_eff,
    input  logic [ROB_DEPTH-1:0]       term,
    input  logic                       hold,
    output logic [NW-1:0]              n,
    output logic [RETIRE_W*IDX_BW-1:0] lane_idx
);

    logic              run;
    logic [IDX_BW-1:0] idx;

    always_comb begin
        n        = '0;
        lane_idx = '0;
        idx      = '0;
        run      = ~hold;
        for (int k = 0; k < RETIRE_W; k++) begin
            idx = rd_idx + IDX_BW'(k);
            lane_idx[k*IDX_BW +: IDX_BW] = idx;
            if (run && (k < int'(count)) && done_eff[idx]) begin
                n   = NW'(k + 1);
                run = ~term[idx];
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rv32i_rob_mw.sv
// Multi-writeback, multi-retire reorder buffer; RV32I_ROB_EXC_EN adds exception tracking and retire blocking.
// Retire outputs registered (1 cycle); dispatch is dropped while full or flushing.
module rv32i_rob_mw
    import rv32i_pkg::*;
#(
    parameter int ROB_DEPTH = rv32i_pkg::ROB_DEPTH,
    parameter int NUM_WB    = 2,
    parameter int RETIRE_W  = 2,
    parameter int IDX_BW    = $clog2(ROB_DEPTH)
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     i_dispatch,
    input  logic                                     i_dst_vld,
    input  logic [PHYS_REG_FILE_IDX_BW-1:0]          i_dst_phys_rf_tag,
    input  logic [ARCH_REG_FILE_IDX_BW-1:0]          i_dst_arch_rf_idx,
    output logic [IDX_BW-1:0]                        o_rob_entry_idx,
    output logic                                     o_full,
    output logic                                     o_empty,
    output logic [IDX_BW:0]                          o_count,
    input  logic [NUM_WB-1:0]                        i_wb_vld,
    input  logic [NUM_WB*IDX_BW-1:0]                 i_wb_rob_entry_idx,
`ifdef RV32I_ROB_EXC_EN
    input  logic [NUM_WB-1:0]                        i_wb_exc,
    output logic                                     o_retire_exc,
    output logic [IDX_BW-1:0]                        o_retire_exc_rob_idx,
`endif
    input  logic                                     i_flush,
    output logic [RETIRE_W-1:0]                      o_retire_vld,
    output logic [RETIRE_W-1:0]                      o_retire_dst_vld,
    output logic [RETIRE_W*PHYS_REG_FILE_IDX_BW-1:0] o_retire_dst_phys_rf_tag,
    output logic [RETIRE_W*ARCH_REG_FILE_IDX_BW-1:0] o_retire_dst_arch_rf_idx
);

    localparam int NW = $clog2(RETIRE_W + 1);
    localparam int PB = PHYS_REG_FILE_IDX_BW;
    localparam int AB = ARCH_REG_FILE_IDX_BW;

    rob_entry_t                 entries [ROB_DEPTH];
    rob_entry_t                 disp_entry;
    logic [IDX_BW:0]            wr_ptr, rd_ptr;
    logic [IDX_BW-1:0]          wr_idx, rd_idx;
    logic                       accept;
    logic                       hold;
    logic [ROB_DEPTH-1:0]       vld_vec, done_vec, wb_hit, done_eff, term, ret_mask;
    logic [NW-1:0]              ret_n;
    logic [RETIRE_W*IDX_BW-1:0] lane_idx;
    logic [RETIRE_W-1:0]        ret_vld_nxt, ret_dst_vld_nxt;
    logic [RETIRE_W*PB-1:0]     ret_tag_nxt;
    logic [RETIRE_W*AB-1:0]     ret_arch_nxt;
`ifdef RV32I_ROB_EXC_EN
    logic [ROB_DEPTH-1:0]       exc_vec, wb_exc_hit;
    logic                       exc_blocked;
    logic                       ret_exc;
    logic [IDX_BW-1:0]          ret_exc_idx;
`endif

    assign wr_idx          = wr_ptr[IDX_BW-1:0];
    assign rd_idx          = rd_ptr[IDX_BW-1:0];
    assign o_rob_entry_idx = wr_idx;
    assign o_count         = wr_ptr - rd_ptr;
    assign o_empty         = (wr_ptr == rd_ptr);
    assign o_full          = (wr_idx == rd_idx) && (wr_ptr[IDX_BW] != rd_ptr[IDX_BW]);
    assign accept          = i_dispatch & ~o_full & ~i_flush;

    always_comb begin
        vld_vec  = '0;
        done_vec = '0;
        wb_hit   = '0;
        for (int i = 0; i < ROB_DEPTH; i++) begin
            vld_vec[i]  = entries[i].vld;
            done_vec[i] = entries[i].done;
        end
        for (int p = 0; p < NUM_WB; p++) begin
            if (i_wb_vld[p]) wb_hit[i_wb_rob_entry_idx[p*IDX_BW +: IDX_BW]] = 1'b1;
        end
        done_eff = (done_vec | wb_hit) & vld_vec;
    end

`ifdef RV32I_ROB_EXC_EN
    always_comb begin
        exc_vec    = '0;
        wb_exc_hit = '0;
        for (int i = 0; i < ROB_DEPTH; i++) exc_vec[i] = entries[i].exc;
        for (int p = 0; p < NUM_WB; p++) begin
            if (i_wb_vld[p] && i_wb_exc[p]) wb_exc_hit[i_wb_rob_entry_idx[p*IDX_BW +: IDX_BW]] = 1'b1;
        end
        term = (exc_vec | wb_exc_hit) & vld_vec;
        hold = i_flush | exc_blocked;
    end
`else
    assign term = '0;
    assign hold = i_flush;
`endif

    rv32i_rob_retire_sel #(
        .ROB_DEPTH (ROB_DEPTH),
        .RETIRE_W  (RETIRE_W)
    ) u_retire_sel (
        .rd_idx   (rd_idx),
        .count    (o_count),
        .done_eff (done_eff),
        .term     (term),
        .hold     (hold),
        .n        (ret_n),
        .lane_idx (lane_idx)
    );

    // Gather the next registered retire bundle; non-retiring lanes stay zero.
    always_comb begin
        ret_mask        = '0;
        ret_vld_nxt     = '0;
        ret_dst_vld_nxt = '0;
        ret_tag_nxt     = '0;
        ret_arch_nxt    = '0;
`ifdef RV32I_ROB_EXC_EN
        ret_exc     = 1'b0;
        ret_exc_idx = '0;
`endif
        for (int k = 0; k < RETIRE_W; k++) begin
            if (k < int'(ret_n)) begin
                ret_mask[lane_idx[k*IDX_BW +: IDX_BW]] = 1'b1;
                ret_vld_nxt[k]          = 1'b1;
                ret_dst_vld_nxt[k]      = entries[lane_idx[k*IDX_BW +: IDX_BW]].dst_vld;
                ret_tag_nxt[k*PB +: PB] = entries[lane_idx[k*IDX_BW +: IDX_BW]].phys_tag;
                ret_arch_nxt[k*AB +: AB] = entries[lane_idx[k*IDX_BW +: IDX_BW]].arch_idx;
`ifdef RV32I_ROB_EXC_EN
                ret_exc     = term[lane_idx[k*IDX_BW +: IDX_BW]];
                ret_exc_idx = lane_idx[k*IDX_BW +: IDX_BW];
`endif
            end
        end
    end

    always_comb begin
        disp_entry          = '0;
        disp_entry.vld      = 1'b1;
        disp_entry.dst_vld  = i_dst_vld;
        disp_entry.phys_tag = i_dst_phys_rf_tag;
        disp_entry.arch_idx = i_dst_arch_rf_idx;
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            wr_ptr                   <= '0;
            rd_ptr                   <= '0;
            o_retire_vld             <= '0;
            o_retire_dst_vld         <= '0;
            o_retire_dst_phys_rf_tag <= '0;
            o_retire_dst_arch_rf_idx <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) entries[i] <= '0;
`ifdef RV32I_ROB_EXC_EN
            exc_blocked          <= 1'b0;
            o_retire_exc         <= 1'b0;
            o_retire_exc_rob_idx <= '0;
`endif
        end else begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                if (ret_mask[i]) begin
                    entries[i].vld  <= 1'b0;
                    entries[i].done <= 1'b0;
`ifdef RV32I_ROB_EXC_EN
                    entries[i].exc  <= 1'b0;
`endif
                end else if (wb_hit[i] && entries[i].vld) begin
                    entries[i].done <= 1'b1;
`ifdef RV32I_ROB_EXC_EN
                    entries[i].exc  <= entries[i].exc | wb_exc_hit[i];
`endif
                end
            end
            // The write slot is never occupied when accepting, so this cannot collide with the updates above.
            if (accept) entries[wr_idx] <= disp_entry;
            wr_ptr                   <= wr_ptr + {{IDX_BW{1'b0}}, accept};
            rd_ptr                   <= rd_ptr + (IDX_BW+1)'(ret_n);
            o_retire_vld             <= ret_vld_nxt;
            o_retire_dst_vld         <= ret_dst_vld_nxt;
            o_retire_dst_phys_rf_tag <= ret_tag_nxt;
            o_retire_dst_arch_rf_idx <= ret_arch_nxt;
`ifdef RV32I_ROB_EXC_EN
            exc_blocked          <= exc_blocked | ret_exc;
            o_retire_exc         <= ret_exc;
            o_retire_exc_rob_idx <= ret_exc ? ret_exc_idx : '0;
`endif
        end
    end

endmodule

// File: tb/tb_rv32i_rob_mw.sv
// Directed bench for rv32i_rob_mw: reset, ordering/bypass, full, wrap, flush and (RV32I_ROB_EXC_EN) exceptions.
module tb_rv32i_rob_mw;
    import rv32i_pkg::*;

    localparam int IB = 4;
    localparam int P  = PHYS_REG_FILE_IDX_BW;
    localparam int A  = ARCH_REG_FILE_IDX_BW;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_dispatch, i_dst_vld, i_flush;
    logic [P-1:0]  i_dst_phys_rf_tag;
    logic [A-1:0]  i_dst_arch_rf_idx;
    logic [IB-1:0] o_rob_entry_idx;
    logic          o_full, o_empty;
    logic [IB:0]   o_count;
    logic [1:0]    i_wb_vld;
    logic [2*IB-1:0] i_wb_rob_entry_idx;
    logic [1:0]    o_retire_vld, o_retire_dst_vld;
    logic [2*P-1:0] o_retire_dst_phys_rf_tag;
    logic [2*A-1:0] o_retire_dst_arch_rf_idx;
`ifdef RV32I_ROB_EXC_EN
    logic [1:0]    i_wb_exc;
    logic          o_retire_exc;
    logic [IB-1:0] o_retire_exc_rob_idx;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    rv32i_rob_mw dut (
        .clk                      (clk),
        .rst                      (rst),
        .i_dispatch               (i_dispatch),
        .i_dst_vld                (i_dst_vld),
        .i_dst_phys_rf_tag        (i_dst_phys_rf_tag),
        .i_dst_arch_rf_idx        (i_dst_arch_rf_idx),
        .o_rob_entry_idx          (o_rob_entry_idx),
        .o_full                   (o_full),
        .o_empty                  (o_empty),
        .o_count                  (o_count),
        .i_wb_vld                 (i_wb_vld),
        .i_wb_rob_entry_idx       (i_wb_rob_entry_idx),
`ifdef RV32I_ROB_EXC_EN
        .i_wb_exc                 (i_wb_exc),
        .o_retire_exc             (o_retire_exc),
        .o_retire_exc_rob_idx     (o_retire_exc_rob_idx),
`endif
        .i_flush                  (i_flush),
        .o_retire_vld             (o_retire_vld),
        .o_retire_dst_vld         (o_retire_dst_vld),
        .o_retire_dst_phys_rf_tag (o_retire_dst_phys_rf_tag),
        .o_retire_dst_arch_rf_idx (o_retire_dst_arch_rf_idx)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        i_dispatch         = 1'b0;
        i_dst_vld          = 1'b0;
        i_dst_phys_rf_tag  = '0;
        i_dst_arch_rf_idx  = '0;
        i_wb_vld           = '0;
        i_wb_rob_entry_idx = '0;
        i_flush            = 1'b0;
`ifdef RV32I_ROB_EXC_EN
        i_wb_exc           = '0;
`endif
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic dispatch(input int tag, input int arch);
        i_dispatch        = 1'b1;
        i_dst_vld         = 1'b1;
        i_dst_phys_rf_tag = P'(tag);
        i_dst_arch_rf_idx = A'(arch);
        tick;
        i_dispatch        = 1'b0;
    endtask

    task automatic test_reset;
        for (int c = 0; c < 6; c++) begin
            i_dispatch         = 1'($urandom_range(1));
            i_dst_vld          = 1'b1;
            i_dst_phys_rf_tag  = P'($urandom);
            i_wb_vld           = 2'($urandom);
            i_wb_rob_entry_idx = (2*IB)'($urandom_range(3) * 17);
            tick;
        end
        rst = 1'b1;
        tick;
        tests_run++; if (o_retire_vld !== 2'b00) begin tests_failed++; $display("FAIL reset_no_retire: got %b expected 00", o_retire_vld); end
        tick;
        rst = 1'b0;
        idle;
        tests_run++; if (o_empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty: got %b expected 1", o_empty); end
        tests_run++; if (o_full !== 1'b0) begin tests_failed++; $display("FAIL reset_full: got %b expected 0", o_full); end
        tests_run++; if (o_count !== 5'd0) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", o_count); end
        tests_run++; if (o_rob_entry_idx !== 4'd0) begin tests_failed++; $display("FAIL reset_idx: got %0d expected 0", o_rob_entry_idx); end
        tests_run++; if (o_retire_vld !== 2'b00) begin tests_failed++; $display("FAIL reset_retire: got %b expected 00", o_retire_vld); end
    endtask

    task automatic test_ordering;
        for (int j = 0; j < 3; j++) begin
            tests_run++; if (o_rob_entry_idx !== IB'(j)) begin tests_failed++; $display("FAIL order_idx%0d: got %0d expected %0d", j, o_rob_entry_idx, j); end
            dispatch(33 + j, 1 + j);
        end
        i_wb_vld = 2'b01; i_wb_rob_entry_idx = {4'd0, 4'd2};
        tick;
        tests_run++; if (o_retire_vld !== 2'b00) begin tests_failed++; $display("FAIL order_ooo_hold: got %b expected 00", o_retire_vld); end
        i_wb_vld = 2'b10; i_wb_rob_entry_idx = {4'd0, 4'd0};
        tick;
        tests_run++; if (o_retire_vld !== 2'b01) begin tests_failed++; $display("FAIL order_bypass_vld: got %b expected 01", o_retire_vld); end
        tests_run++; if (o_retire_dst_phys_rf_tag[0 +: P] !== P'(33)) begin tests_failed++; $display("FAIL order_tag0: got %0d expected 33", o_retire_dst_phys_rf_tag[0 +: P]); end
        tests_run++; if (o_retire_dst_arch_rf_idx[0 +: A] !== A'(1)) begin tests_failed++; $display("FAIL order_arch0: got %0d expected 1", o_retire_dst_arch_rf_idx[0 +: A]); end
        tests_run++; if (o_retire_dst_phys_rf_tag[P +: P] !== P'(0)) begin tests_failed++; $display("FAIL order_lane1_zero: got %0d expected 0", o_retire_dst_phys_rf_tag[P +: P]); end
        i_wb_vld = 2'b01; i_wb_rob_entry_idx = {4'd0, 4'd1};
        tick;
        tests_run++; if (o_retire_vld !== 2'b11) begin tests_failed++; $display("FAIL order_pair_vld: got %b expected 11", o_retire_vld); end
        tests_run++; if (o_retire_dst_phys_rf_tag[0 +: P] !== P'(34)) begin tests_failed++; $display("FAIL order_pair_tag0: got %0d expected 34", o_retire_dst_phys_rf_tag[0 +: P]); end
        tests_run++; if (o_retire_dst_phys_rf_tag[P +: P] !== P'(35)) begin tests_failed++; $display("FAIL order_pair_tag1: got %0d expected 35", o_retire_dst_phys_rf_tag[P +: P]); end
        tests_run++; if (o_retire_dst_arch_rf_idx[A +: A] !== A'(3)) begin tests_failed++; $display("FAIL order_pair_arch1: got %0d expected 3", o_retire_dst_arch_rf_idx[A +: A]); end
        idle;
        tick;
        tests_run++; if (o_retire_vld !== 2'b00) begin tests_failed++; $display("FAIL order_quiet: got %b expected 00", o_retire_vld); end
        tests_run++; if (o_empty !== 1'b1) begin tests_failed++; $display("FAIL order_empty: got %b expected 1", o_empty); end
    endtask

    task automatic test_full;
        do_reset;
        for (int j = 0; j < 16; j++) dispatch(j + 8, j);
        tests_run++; if (o_full !== 1'b1) begin tests_failed++; $display("FAIL full_flag: got %b expected 1", o_full); end
        tests_run++; if (o_count !== 5'd16) begin tests_failed++; $display("FAIL full_count: got %0d expected 16", o_count); end
        i_dispatch = 1'b1; i_dst_phys_rf_tag = P'(63);
        tests_run++; if (o_rob_entry_idx !== 4'd0) begin tests_failed++; $display("FAIL full_idx: got %0d expected 0", o_rob_entry_idx); end
        tick;
        tests_run++; if (o_count !== 5'd16) begin tests_failed++; $display("FAIL full_drop_count: got %0d expected 16", o_count); end
        for (int c = 0; c < 8; c++) begin
            i_dispatch = (c == 0);
            i_wb_vld = 2'b11;
            i_wb_rob_entry_idx = {IB'(2*c + 1), IB'(2*c)};
            tick;
            tests_run++; if (o_retire_vld !== 2'b11) begin tests_failed++; $display("FAIL drain_vld%0d: got %b expected 11", c, o_retire_vld); end
            tests_run++; if (o_retire_dst_phys_rf_tag[0 +: P] !== P'(2*c + 8)) begin tests_failed++; $display("FAIL drain_tag0_%0d: got %0d expected %0d", c, o_retire_dst_phys_rf_tag[0 +: P], 2*c + 8); end
            tests_run++; if (o_retire_dst_phys_rf_tag[P +: P] !== P'(2*c + 9)) begin tests_failed++; $display("FAIL drain_tag1_%0d: got %0d expected %0d", c, o_retire_dst_phys_rf_tag[P +: P], 2*c + 9); end
            if (c == 0) begin
                tests_run++; if (o_count !== 5'd14) begin tests_failed++; $display("FAIL full_retire_reject: got %0d expected 14", o_count); end
            end
        end
        idle;
        tests_run++; if (o_empty !== 1'b1) begin tests_failed++; $display("FAIL drain_empty: got %b expected 1", o_empty); end
    endtask

    task automatic test_wrap;
        for (int k = 0; k < 40; k++) begin
            i_dispatch = 1'b1; i_dst_vld = 1'b1;
            i_dst_phys_rf_tag = P'(k + 10); i_dst_arch_rf_idx = A'(k % 32);
            i_wb_vld = '0;
            if (k % 2 == 1) begin
                i_wb_vld = (k >= 3) ? 2'b11 : 2'b10;
                i_wb_rob_entry_idx = {IB'((k - 1) % 16), IB'((k + 14) % 16)};
            end
            tests_run++; if (o_rob_entry_idx !== IB'(k % 16)) begin tests_failed++; $display("FAIL wrap_idx%0d: got %0d expected %0d", k, o_rob_entry_idx, k % 16); end
            tick;
            if (k % 2 == 1) begin
                tests_run++; if (o_retire_vld !== ((k == 1) ? 2'b01 : 2'b11)) begin tests_failed++; $display("FAIL wrap_vld%0d: got %b", k, o_retire_vld); end
                tests_run++; if (o_retire_dst_phys_rf_tag[0 +: P] !== P'((k == 1) ? 10 : k + 8)) begin tests_failed++; $display("FAIL wrap_tag0_%0d: got %0d", k, o_retire_dst_phys_rf_tag[0 +: P]); end
                if (k >= 3) begin
                    tests_run++; if (o_retire_dst_phys_rf_tag[P +: P] !== P'(k + 9)) begin tests_failed++; $display("FAIL wrap_tag1_%0d: got %0d expected %0d", k, o_retire_dst_phys_rf_tag[P +: P], k + 9); end
                end
            end else begin
                tests_run++; if (o_retire_vld !== 2'b00) begin tests_failed++; $display("FAIL wrap_quiet%0d: got %b expected 00", k, o_retire_vld); end
            end
            tests_run++; if (o_count !== ((k % 2 == 1 || k == 0) ? 5'd1 : 5'd2)) begin tests_failed++; $display("FAIL wrap_count%0d: got %0d", k, o_count); end
            tests_run++; if (o_full !== 1'b0) begin tests_failed++; $display("FAIL wrap_full%0d: got %b expected 0", k, o_full); end
        end
        i_dispatch = 1'b0;
        i_wb_vld = 2'b01; i_wb_rob_entry_idx = {4'd0, 4'd7};
        tick;
        tests_run++; if (o_retire_dst_phys_rf_tag[0 +: P] !== P'(49)) begin tests_failed++; $display("FAIL wrap_last_tag: got %0d expected 49", o_retire_dst_phys_rf_tag[0 +: P]); end
        idle;
        tests_run++; if (o_empty !== 1'b1) begin tests_failed++; $display("FAIL wrap_empty: got %b expected 1", o_empty); end
    endtask

    task automatic test_flush;
        do_reset;
        for (int j = 0; j < 10; j++) dispatch(j + 1, j);
        i_flush = 1'b1; i_dispatch = 1'b1;
        i_wb_vld = 2'b11; i_wb_rob_entry_idx = {4'd1, 4'd0};
        tick;
        idle;
        tests_run++; if (o_count !== 5'd0) begin tests_failed++; $display("FAIL flush_count: got %0d expected 0", o_count); end
        tests_run++; if (o_retire_vld !== 2'b00) begin tests_failed++; $display("FAIL flush_retire: got %b expected 00", o_retire_vld); end
        tests_run++; if (o_rob_entry_idx !== 4'd0) begin tests_failed++; $display("FAIL flush_idx: got %0d expected 0", o_rob_entry_idx); end
        tick;
        tests_run++; if (o_retire_vld !== 2'b00) begin tests_failed++; $display("FAIL flush_late_retire: got %b expected 00", o_retire_vld); end
        dispatch(5, 5);
        tests_run++; if (o_count !== 5'd1) begin tests_failed++; $display("FAIL flush_redispatch: got %0d expected 1", o_count); end
        i_wb_vld = 2'b01; i_wb_rob_entry_idx = '0;
        tick;
        idle;
        tests_run++; if (o_retire_dst_phys_rf_tag[0 +: P] !== P'(5)) begin tests_failed++; $display("FAIL flush_new_tag: got %0d expected 5", o_retire_dst_phys_rf_tag[0 +: P]); end
    endtask

`ifdef RV32I_ROB_EXC_EN
    task automatic test_exc;
        do_reset;
        for (int j = 0; j < 4; j++) dispatch(20 + j, j);
        i_wb_vld = 2'b11; i_wb_rob_entry_idx = {4'd1, 4'd0}; i_wb_exc = 2'b10;
        tick;
        i_wb_exc = '0;
        tests_run++; if (o_retire_vld !== 2'b11) begin tests_failed++; $display("FAIL exc_vld: got %b expected 11", o_retire_vld); end
        tests_run++; if (o_retire_exc !== 1'b1) begin tests_failed++; $display("FAIL exc_flag: got %b expected 1", o_retire_exc); end
        tests_run++; if (o_retire_exc_rob_idx !== 4'd1) begin tests_failed++; $display("FAIL exc_idx: got %0d expected 1", o_retire_exc_rob_idx); end
        i_wb_vld = 2'b01; i_wb_rob_entry_idx = {4'd0, 4'd2};
        tick;
        idle;
        tests_run++; if (o_retire_vld !== 2'b00) begin tests_failed++; $display("FAIL exc_block: got %b expected 00", o_retire_vld); end
        tests_run++; if (o_retire_exc !== 1'b0) begin tests_failed++; $display("FAIL exc_pulse: got %b expected 0", o_retire_exc); end
        dispatch(30, 0);
        tests_run++; if (o_count !== 5'd3) begin tests_failed++; $display("FAIL exc_dispatch: got %0d expected 3", o_count); end
        i_flush = 1'b1;
        tick;
        i_flush = 1'b0;
        tests_run++; if (o_count !== 5'd0) begin tests_failed++; $display("FAIL exc_flush: got %0d expected 0", o_count); end
        dispatch(40, 0);
        i_wb_vld = 2'b01; i_wb_rob_entry_idx = '0;
        tick;
        idle;
        tests_run++; if (o_retire_vld !== 2'b01) begin tests_failed++; $display("FAIL exc_unblock: got %b expected 01", o_retire_vld); end
    endtask
`endif

    initial begin
        idle;
        do_reset;
        test_reset;
        test_ordering;
        test_full;
        test_wrap;
        test_flush;
`ifdef RV32I_ROB_EXC_EN
        test_exc;
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
